// File: rtl/cp0_reg.sv
// Coprocessor-0 register file: exception state, mtc0/mfc0, interrupt sampling.
// Optional Count/Compare timer interrupt is compiled in with `define CP0_TIMER_INT_EN.
module cp0_reg #(
  parameter logic [31:0] RESET_STATUS = 32'h0040_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [4:0]  raddr_i,
  input  logic [31:0] data_i,
  input  logic [5:0]  int_i,
  input  logic [31:0] except_type_i,
  input  logic [31:0] current_inst_addr_i,
  input  logic        is_in_delayslot_i,
  input  logic [31:0] bad_addr_i,
  output logic [31:0] data_o,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic [31:0] status_o,
  output logic [31:0] cause_o,
  output logic [31:0] epc_o,
  output logic [31:0] badvaddr_o,
  output logic        timer_int_o
);

  localparam logic [4:0] REG_BADVADDR = 5'd8;
  localparam logic [4:0] REG_COUNT    = 5'd9;
  localparam logic [4:0] REG_COMPARE  = 5'd11;
  localparam logic [4:0] REG_STATUS   = 5'd12;
  localparam logic [4:0] REG_CAUSE    = 5'd13;
  localparam logic [4:0] REG_EPC      = 5'd14;

  logic [31:0] count;
  logic [31:0] compare;
  logic [31:0] status;
  logic [31:0] cause;
  logic [31:0] epc;
  logic [31:0] badvaddr;
  logic        exc_hit;
  logic        eret_hit;
  logic        addr_exc;

  always_comb begin
    exc_hit  = 1'b0;
    addr_exc = 1'b0;
    case (except_type_i)
      32'h1, 32'h8, 32'h9, 32'ha, 32'hc: exc_hit = 1'b1;
      32'h4, 32'h5: begin
        exc_hit  = 1'b1;
        addr_exc = 1'b1;
      end
      default: ;
    endcase
    eret_hit = (except_type_i == 32'he);
  end

`ifdef CP0_TIMER_INT_EN
  logic toggle;
  logic timer_int;

  always_ff @(posedge clk) begin
    if (rst) begin
      toggle    <= 1'b0;
      timer_int <= 1'b0;
    end else begin
      toggle <= ~toggle;
      if (compare != 32'h0 && count == compare)
        timer_int <= 1'b1;
      if (we_i && waddr_i == REG_COMPARE)
        timer_int <= 1'b0;
    end
  end

  assign timer_int_o = timer_int;
`else
  assign timer_int_o = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      count    <= 32'h0;
      compare  <= 32'h0;
      status   <= RESET_STATUS;
      cause    <= 32'h0;
      epc      <= 32'h0;
      badvaddr <= 32'h0;
    end else begin
      cause[15:10] <= int_i;
`ifdef CP0_TIMER_INT_EN
      cause[15] <= int_i[5] | timer_int;
      if (toggle)
        count <= count + 32'h1;
`endif
      if (we_i) begin
        case (waddr_i)
          REG_COUNT:   count      <= data_i;
          REG_COMPARE: compare    <= data_i;
          REG_STATUS:  status     <= data_i;
          REG_CAUSE:   cause[9:8] <= data_i[9:8];
          REG_EPC:     epc        <= data_i;
          default: ;
        endcase
      end
      // Exception/ERET come last so they override any mtc0 to the same field.
      if (exc_hit) begin
        if (!status[1]) begin
          if (is_in_delayslot_i) begin
            epc       <= current_inst_addr_i - 32'h4;
            cause[31] <= 1'b1;
          end else begin
            epc       <= current_inst_addr_i;
            cause[31] <= 1'b0;
          end
        end
        status[1]  <= 1'b1;
        cause[6:2] <= except_type_i[4:0];
        if (addr_exc)
          badvaddr <= bad_addr_i;
      end else if (eret_hit) begin
        status[1] <= 1'b0;
      end
    end
  end

  always_comb begin
    data_o = 32'h0;
    case (raddr_i)
      REG_BADVADDR: data_o = badvaddr;
      REG_COUNT:    data_o = count;
      REG_COMPARE:  data_o = compare;
      REG_STATUS:   data_o = status;
      REG_CAUSE:    data_o = cause;
      REG_EPC:      data_o = epc;
      default:      data_o = 32'h0;
    endcase
  end

  assign count_o    = count;
  assign compare_o  = compare;
  assign status_o   = status;
  assign cause_o    = cause;
  assign epc_o      = epc;
  assign badvaddr_o = badvaddr;

endmodule

// File: tb/tb_cp0_reg.sv
// Directed, table-driven bench for cp0_reg; timer checks follow CP0_TIMER_INT_EN.
module tb_cp0_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic        we_i;
  logic [4:0]  waddr_i;
  logic [4:0]  raddr_i;
  logic [31:0] data_i;
  logic [5:0]  int_i;
  logic [31:0] except_type_i;
  logic [31:0] current_inst_addr_i;
  logic        is_in_delayslot_i;
  logic [31:0] bad_addr_i;
  logic [31:0] data_o, count_o, compare_o, status_o, cause_o, epc_o, badvaddr_o;
  logic        timer_int_o;

  int n_checks = 0;
  int n_fail   = 0;

  cp0_reg #(.RESET_STATUS(32'h0040_0000)) dut (
    .clk(clk), .rst(rst), .we_i(we_i), .waddr_i(waddr_i), .raddr_i(raddr_i),
    .data_i(data_i), .int_i(int_i), .except_type_i(except_type_i),
    .current_inst_addr_i(current_inst_addr_i), .is_in_delayslot_i(is_in_delayslot_i),
    .bad_addr_i(bad_addr_i), .data_o(data_o), .count_o(count_o), .compare_o(compare_o),
    .status_o(status_o), .cause_o(cause_o), .epc_o(epc_o), .badvaddr_o(badvaddr_o),
    .timer_int_o(timer_int_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [5:0]  irq;
    logic [31:0] etype;
    logic [31:0] pc;
    logic        ds;
    logic [31:0] bad;
    logic [4:0]  raddr;
    logic [31:0] mask;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic idle();
    we_i = 1'b0; waddr_i = '0; data_i = '0; int_i = '0; except_type_i = '0;
    current_inst_addr_i = '0; is_in_delayslot_i = 1'b0; bad_addr_i = '0;
  endtask

  task automatic add(input string n, input logic we, input logic [4:0] wa, input logic [31:0] wd,
                     input logic [5:0] irq, input logic [31:0] et, input logic [31:0] pc,
                     input logic ds, input logic [31:0] bad, input logic [4:0] ra,
                     input logic [31:0] mask, input logic [31:0] exp);
    vec_t v;
    v.name = n; v.we = we; v.waddr = wa; v.wdata = wd; v.irq = irq; v.etype = et;
    v.pc = pc; v.ds = ds; v.bad = bad; v.raddr = ra; v.mask = mask; v.exp = exp;
    vecs.push_back(v);
  endtask

  task automatic mtc0(input logic [4:0] wa, input logic [31:0] wd);
    @(negedge clk);
    idle();
    we_i = 1'b1; waddr_i = wa; data_i = wd;
    @(posedge clk); #1;
    @(negedge clk);
    idle();
  endtask

  localparam logic [31:0] ALL = 32'hFFFF_FFFF;

  initial begin
    int edges;
    bit seen;
    idle();
    raddr_i = 5'd0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    raddr_i = 5'd12; #1 check("reset_status", data_o, 32'h0040_0000);
    raddr_i = 5'd13; #1 check("reset_cause", data_o, 32'h0);
    raddr_i = 5'd14; #1 check("reset_epc", data_o, 32'h0);
    check("reset_timer_int", {31'h0, timer_int_o}, 32'h0);
    check("reset_badvaddr", badvaddr_o, 32'h0);
    check("reset_compare", compare_o, 32'h0);

    //   name            we wa     wdata         irq       type    pc            ds bad           ra     mask  exp
    add("syscall_epc",   0, 5'd0,  32'h0,        6'h00, 32'h08, 32'hBFC0_0100, 0, 32'h0,        5'd14, ALL, 32'hBFC0_0100);
    add("syscall_cause", 0, 5'd0,  32'h0,        6'h00, 32'h00, 32'h0,         0, 32'h0,        5'd13, ALL, 32'h0000_0020);
    add("syscall_exl",   0, 5'd0,  32'h0,        6'h00, 32'h00, 32'h0,         0, 32'h0,        5'd12, ALL, 32'h0040_0002);
    add("eret_status",   0, 5'd0,  32'h0,        6'h00, 32'h0e, 32'h1234,      0, 32'h0,        5'd12, ALL, 32'h0040_0000);
    add("eret_epc_keep", 0, 5'd0,  32'h0,        6'h00, 32'h00, 32'h0,         0, 32'h0,        5'd14, ALL, 32'hBFC0_0100);
    add("adel_epc_ds",   0, 5'd0,  32'h0,        6'h00, 32'h04, 32'h8000_0010, 1, 32'h8000_0003, 5'd14, ALL, 32'h8000_000C);
    add("adel_cause",    0, 5'd0,  32'h0,        6'h00, 32'h00, 32'h0,         0, 32'h0,        5'd13, ALL, 32'h8000_0010);
    add("adel_badvaddr", 0, 5'd0,  32'h0,        6'h00, 32'h00, 32'h0,         0, 32'h0,        5'd8,  ALL, 32'h8000_0003);
    add("exl1_epc_keep", 0, 5'd0,  32'h0,        6'h00, 32'h08, 32'h8000_0200, 0, 32'hAAAA_0000, 5'd14, ALL, 32'h8000_000C);
    add("exl1_cause",    0, 5'd0,  32'h0,        6'h00, 32'h00, 32'h0,         0, 32'h0,        5'd13, ALL, 32'h8000_0020);
    add("exl1_bva_keep", 0, 5'd0,  32'h0,        6'h00, 32'h00, 32'h0,         0, 32'h0,        5'd8,  ALL, 32'h8000_0003);
    add("eret2",         0, 5'd0,  32'h0,        6'h00, 32'h0e, 32'h0,         0, 32'h0,        5'd12, ALL, 32'h0040_0000);
    add("bva_ro",        1, 5'd8,  32'h0000_1234, 6'h00, 32'h00, 32'h0,        0, 32'h0,        5'd8,  ALL, 32'h8000_0003);
    add("cause_ip_wr",   1, 5'd13, 32'hFFFF_FFFF, 6'h00, 32'h00, 32'h0,        0, 32'h0,        5'd13, ALL, 32'h8000_0320);
    add("cause_hw_int",  0, 5'd0,  32'h0,        6'h2A, 32'h00, 32'h0,         0, 32'h0,        5'd13, ALL, 32'h8000_AB20);
    add("cause_int_clr", 0, 5'd0,  32'h0,        6'h00, 32'h00, 32'h0,         0, 32'h0,        5'd13, ALL, 32'h8000_0320);
    add("mtc0_ov_cause", 1, 5'd12, 32'h0000_0001, 6'h00, 32'h0c, 32'h0000_0100, 0, 32'h0,       5'd13, ALL, 32'h0000_0330);
    add("mtc0_ov_exl",   0, 5'd0,  32'h0,        6'h00, 32'h00, 32'h0,         0, 32'h0,        5'd12, 32'h2, 32'h2);
    add("mtc0_ov_epc",   0, 5'd0,  32'h0,        6'h00, 32'h00, 32'h0,         0, 32'h0,        5'd14, ALL, 32'h0000_0100);
    add("eret3",         0, 5'd0,  32'h0,        6'h00, 32'h0e, 32'h0,         0, 32'h0,        5'd12, 32'h2, 32'h0);
    add("unlisted_type", 0, 5'd0,  32'h0,        6'h00, 32'h03, 32'h0000_5555, 1, 32'h0,        5'd14, ALL, 32'h0000_0100);
    add("unlisted_exl",  0, 5'd0,  32'h0,        6'h00, 32'h00, 32'h0,         0, 32'h0,        5'd12, 32'h2, 32'h0);
    add("epc_write",     1, 5'd14, 32'hDEAD_BEEF, 6'h00, 32'h00, 32'h0,        0, 32'h0,        5'd14, ALL, 32'hDEAD_BEEF);
    add("compare_write", 1, 5'd11, 32'h0000_0055, 6'h00, 32'h00, 32'h0,        0, 32'h0,        5'd11, ALL, 32'h0000_0055);
    add("count_write",   1, 5'd9,  32'h0000_0077, 6'h00, 32'h00, 32'h0,        0, 32'h0,        5'd9,  ALL, 32'h0000_0077);
    add("ades_bva",      0, 5'd0,  32'h0,        6'h00, 32'h05, 32'h0000_0400, 0, 32'h0000_0ABD, 5'd8, ALL, 32'h0000_0ABD);
    add("unmapped_read", 0, 5'd0,  32'h0,        6'h00, 32'h00, 32'h0,         0, 32'h0,        5'd5,  ALL, 32'h0);

    foreach (vecs[i]) begin
      @(negedge clk);
      we_i = vecs[i].we; waddr_i = vecs[i].waddr; data_i = vecs[i].wdata;
      int_i = vecs[i].irq; except_type_i = vecs[i].etype;
      current_inst_addr_i = vecs[i].pc; is_in_delayslot_i = vecs[i].ds;
      bad_addr_i = vecs[i].bad; raddr_i = vecs[i].raddr;
      @(posedge clk); #1;
      check(vecs[i].name, data_o & vecs[i].mask, vecs[i].exp);
    end
    @(negedge clk);
    idle();
    mtc0(5'd12, 32'h0040_0000);

`ifdef CP0_TIMER_INT_EN
    mtc0(5'd11, 32'd10);
    mtc0(5'd9, 32'd0);
    edges = 0;
    seen = 1'b0;
    for (int n = 1; n <= 40 && !seen; n++) begin
      @(posedge clk); #1;
      edges = n;
      if (timer_int_o) seen = 1'b1;
    end
    n_checks++;
    if (!seen || edges < 20 || edges > 21) begin
      n_fail++;
      $display("FAIL timer_latency: seen=%0d after %0d edges, required 20..21", seen, edges);
    end
    @(posedge clk); #1;
    check("timer_cause_ip7", {31'h0, cause_o[15]}, 32'h1);
    check("timer_int_held", {31'h0, timer_int_o}, 32'h1);
    mtc0(5'd11, 32'h0001_0000);
    check("timer_clear", {31'h0, timer_int_o}, 32'h0);
    mtc0(5'd9, 32'hFFFF_FFFF);
    for (int n = 0; n < 3 && count_o == 32'hFFFF_FFFF; n++) begin
      @(posedge clk); #1;
    end
    check("count_wrap", count_o, 32'h0);
`else
    mtc0(5'd9, 32'h0000_0077);
    mtc0(5'd11, 32'h0000_0077);
    repeat (6) @(posedge clk);
    #1;
    check("count_static", count_o, 32'h0000_0077);
    check("timer_tied_off", {31'h0, timer_int_o}, 32'h0);
    @(negedge clk);
    int_i = 6'h20;
    @(posedge clk); #1;
    check("cause15_is_int5", cause_o & 32'h0000_FC00, 32'h0000_8000);
`endif

    @(negedge clk);
    idle();
    rst = 1'b1;
    we_i = 1'b1; waddr_i = 5'd12; data_i = 32'hFFFF_FFFF;
    except_type_i = 32'h08; current_inst_addr_i = 32'h0000_1234;
    int_i = 6'h3F;
    @(posedge clk); #1;
    check("rst_over_status", status_o, 32'h0040_0000);
    check("rst_over_epc", epc_o, 32'h0);
    check("rst_over_cause", cause_o, 32'h0);
    check("rst_over_count", count_o, 32'h0);
    @(negedge clk);
    idle();
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
